// File: rtl/spramx32_pkg.sv
// Shared word/lane constants and the byte-lane merge used by the spramx32 write path.
package spramx32_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LANES  = WORD_W / 8;

   // Replace only the byte lanes whose enable bit is set; the other lanes keep old_w.
   function automatic logic [WORD_W-1:0] merge_lanes(
      input logic [WORD_W-1:0] old_w,
      input logic [WORD_W-1:0] new_w,
      input logic [LANES-1:0]  lane_en
   );
      logic [WORD_W-1:0] r;
      r = old_w;
      for (int i = 0; i < int'(LANES); i++) begin
         if (lane_en[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/spramx32.sv
// spramx32: single-port 32-bit-wide RAM behind a pipelined Wishbone slave.
// Handshake: a request is taken on every rising edge with cyc=1 and stb=1
// (stall is tied low), and ack answers it exactly one cycle later, so
// back-to-back requests stream at one per clock. Read data is registered at
// the accepting edge and held while no new read is accepted. Reset clears
// ack and dat_s asynchronously but never touches the storage array.
module spramx32
   import spramx32_pkg::*;
#(
   parameter int unsigned size      = 'h10000,
   parameter string       init_file = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [3:0]  sel,
   input  logic [31:0] dat_m,
   output logic [31:0] dat_s,
   output logic        ack,
   output logic        stall,
   output logic        err
);

   localparam int unsigned ADDR_W = $clog2(size);
   localparam int unsigned DEPTH  = size / 4;

   // Storage; left unreset so a preload survives rst_n.
   logic [WORD_W-1:0] mem [0:DEPTH-1];

   logic [ADDR_W-3:0] widx;
   logic              accept;
   logic              unused_adr_bits;

   logic              ack_q, ack_d;
   logic [31:0]       dat_s_q, dat_s_d;

   // Address bits above the capacity alias; the byte offset is irrelevant for whole-word access.
   assign widx            = adr[ADDR_W-1:2];
   assign unused_adr_bits = ^{adr[31:ADDR_W], adr[1:0]};

   // stall is never raised, so cyc & stb is the acceptance condition.
   assign accept = cyc & stb;

   // Byte-lane write at the accepting edge; sel=0 writes the word back unchanged.
   always_ff @(posedge clk) begin
      if (accept && we) mem[widx] <= merge_lanes(mem[widx], dat_m, sel);
   end

   // Next ack mirrors this cycle's acceptance; read data updates only on an accepted read.
   always_comb begin
      ack_d   = accept;
      dat_s_d = dat_s_q;
      if (accept && !we) dat_s_d = mem[widx];
   end

   // Response registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         dat_s_q <= 32'h0;
      end else begin
         ack_q   <= ack_d;
         dat_s_q <= dat_s_d;
      end
   end

   assign ack   = ack_q;
   assign dat_s = dat_s_q;
   assign stall = 1'b0;
   assign err   = 1'b0;

endmodule

// File: tb/tb_spramx32.sv
// Bench for spramx32: directed vector table, hand-written reset/cyc-drop
// sequences, then random traffic checked against a word-array memory model.
module tb_spramx32;

   logic        clk;
   logic        rst_n;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   logic        stall;
   logic        err;

   int total;
   int bad;

   // reference model: one entry per word of a 'h10000-byte memory
   logic [31:0] model_mem [0:16383];
   logic        exp_ack;
   logic [31:0] exp_dat;

   typedef struct {
      logic        c;
      logic        s;
      logic        w;
      logic [31:0] a;
      logic [3:0]  sl;
      logic [31:0] d;
      logic        e_ack;
      logic [31:0] e_dat;
   } vec_t;

   vec_t vecs [16];

   spramx32 #(.size('h10000), .init_file("")) ram (
      .clk   (clk),
      .rst_n (rst_n),
      .cyc   (cyc),
      .stb   (stb),
      .we    (we),
      .adr   (adr),
      .sel   (sel),
      .dat_m (dat_m),
      .dat_s (dat_s),
      .ack   (ack),
      .stall (stall),
      .err   (err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mkv(input logic c, input logic s, input logic w,
                                input logic [31:0] a, input logic [3:0] sl,
                                input logic [31:0] d, input logic e_ack,
                                input logic [31:0] e_dat);
      vec_t v;
      v.c = c; v.s = s; v.w = w; v.a = a; v.sl = sl; v.d = d;
      v.e_ack = e_ack; v.e_dat = e_dat;
      return v;
   endfunction

   // Drive one bus cycle, let the edge happen, update the model, sample 1 time unit later.
   task automatic cycle(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
      logic [31:0] word;
      int          idx;
      cyc = c; stb = s; we = w; adr = a; sel = sl; dat_m = d;
      @(posedge clk);
      idx = int'(a[15:2]);
      if (rst_n && c && s) begin
         exp_ack = 1'b1;
         if (w) begin
            word = model_mem[idx];
            for (int k = 0; k < 4; k++) begin
               if (sl[k]) word[8*k +: 8] = d[8*k +: 8];
            end
            model_mem[idx] = word;
         end else begin
            exp_dat = model_mem[idx];
         end
      end else begin
         exp_ack = 1'b0;
      end
      #1;
   endtask

   initial begin
      logic [31:0] v;
      total   = 0;
      bad     = 0;
      rst_n   = 1'b0;
      cyc     = 1'b0;
      stb     = 1'b0;
      we      = 1'b0;
      adr     = 32'h0;
      sel     = 4'h0;
      dat_m   = 32'h0;
      exp_ack = 1'b0;
      exp_dat = 32'h0;

      // preload words 0..15 in both the DUT and the model
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       v = 32'h00000513;
            1:       v = 32'h11111111;
            2:       v = 32'h22222222;
            3:       v = 32'h33333333;
            default: v = $urandom;
         endcase
         model_mem[i] = v;
         ram.mem[i] <= v;
      end

      // reset state
      #12;
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_dat", dat_s, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed table: expectations are the values visible just after each edge
      vecs[0]  = mkv(1, 1, 0, 32'h0,     4'hF, 32'h0,        1, 32'h00000513);
      vecs[1]  = mkv(1, 1, 1, 32'h10,    4'hF, 32'hDEADBEEF, 1, 32'h00000513);
      vecs[2]  = mkv(1, 1, 0, 32'h10,    4'hF, 32'h0,        1, 32'hDEADBEEF);
      vecs[3]  = mkv(1, 1, 1, 32'h10,    4'b0010, 32'h0000AA00, 1, 32'hDEADBEEF);
      vecs[4]  = mkv(0, 0, 0, 32'h0,     4'h0, 32'h0,        0, 32'hDEADBEEF);
      vecs[5]  = mkv(1, 1, 0, 32'h10,    4'h0, 32'h0,        1, 32'hDEADAAEF);
      vecs[6]  = mkv(1, 1, 1, 32'h10,    4'h0, 32'hFFFFFFFF, 1, 32'hDEADAAEF);
      vecs[7]  = mkv(1, 1, 0, 32'h13,    4'h1, 32'h0,        1, 32'hDEADAAEF);
      vecs[8]  = mkv(1, 1, 0, 32'h0,     4'hF, 32'h0,        1, 32'h00000513);
      vecs[9]  = mkv(1, 1, 0, 32'h4,     4'hF, 32'h0,        1, 32'h11111111);
      vecs[10] = mkv(1, 1, 0, 32'h8,     4'hF, 32'h0,        1, 32'h22222222);
      vecs[11] = mkv(1, 1, 0, 32'hC,     4'hF, 32'h0,        1, 32'h33333333);
      vecs[12] = mkv(0, 1, 0, 32'h4,     4'hF, 32'h0,        0, 32'h33333333);
      vecs[13] = mkv(1, 1, 1, 32'h10010, 4'hF, 32'h12345678, 1, 32'h33333333);
      vecs[14] = mkv(1, 1, 0, 32'h10,    4'hF, 32'h0,        1, 32'h12345678);
      vecs[15] = mkv(1, 0, 0, 32'h10,    4'hF, 32'h0,        0, 32'h12345678);

      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].c, vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].sl, vecs[i].d);
         chk($sformatf("vec%0d_ack", i), {31'h0, ack}, {31'h0, vecs[i].e_ack});
         chk($sformatf("vec%0d_dat", i), dat_s, vecs[i].e_dat);
         chk($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
      end

      // cyc drops while an ack is due: the ack still pulses once
      cycle(1, 1, 0, 32'h4, 4'hF, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      #1;
      chk("drop_ack_pulse", {31'h0, ack}, 32'h1);
      chk("drop_dat", dat_s, 32'h11111111);
      @(posedge clk); #1;
      exp_ack = 1'b0;
      chk("drop_ack_gone", {31'h0, ack}, 32'h0);

      // reset asserted in the cycle after a request, with another request pending
      cycle(1, 1, 0, 32'h0, 4'hF, 32'h0);
      chk("prerst_ack", {31'h0, ack}, 32'h1);
      rst_n = 1'b0;
      #1;
      exp_ack = 1'b0;
      exp_dat = 32'h0;
      chk("async_rst_ack", {31'h0, ack}, 32'h0);
      chk("async_rst_dat", dat_s, 32'h0);
      cycle(1, 1, 0, 32'h4, 4'hF, 32'h0);
      chk("inrst_ack", {31'h0, ack}, 32'h0);
      chk("inrst_dat", dat_s, 32'h0);
      chk("mem0_kept", ram.mem[0], 32'h00000513);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 1, 0, 32'h0, 4'hF, 32'h0);
      chk("postrst_ack", {31'h0, ack}, 32'h1);
      chk("postrst_dat", dat_s, 32'h00000513);

      // random traffic on words 0..15 with aliasing upper bits and random byte offsets
      for (int n = 0; n < 400; n++) begin
         logic        rc;
         logic [31:0] ra;
         rc = ($urandom_range(0, 7) != 0);
         ra = {$urandom_range(0, 65535) > 32768 ? 16'($urandom) : 16'h0,
               10'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         cycle(rc, 1'($urandom_range(0, 1) | rc), 1'($urandom_range(0, 1)), ra,
               4'($urandom_range(0, 15)), $urandom);
         chk($sformatf("rnd%0d_ack", n), {31'h0, ack}, {31'h0, exp_ack});
         chk($sformatf("rnd%0d_dat", n), dat_s, exp_dat);
      end

      // final sweep: every word of the active region read back through the bus
      for (int i = 0; i < 16; i++) begin
         cycle(1, 1, 0, 32'(i * 4), 4'h0, 32'h0);
         chk($sformatf("sweep%0d_dat", i), dat_s, model_mem[i]);
         chk($sformatf("sweep%0d_ack", i), {31'h0, ack}, 32'h1);
      end
      cycle(0, 0, 0, 32'h0, 4'h0, 32'h0);
      chk("tail_ack", {31'h0, ack}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
